ddr2_ui_responder: RTL
======================

// Module: ddr2_ui_responder
// PURPOSE
//  Cycle-level responder model of the DDR2 controller user interface, i.e. the far end of ddr2_test_harness.
//  Accepts address-FIFO and data-FIFO writes, stores write data with byte masks in an internal RAM, and returns
//  read bursts as two 128-bit beats on ddr_dvalid_o. Reports almost-full back-pressure and phy-ready after a calibration delay.
//  Used in simulation benches and as an FPGA loop-back target when no DDR2 part is fitted.
// PARAMETERS
//  MEM_AW       8    log2 of RAM depth in 128-bit words (256 words)
//  AF_DEPTH     16   address FIFO depth (commands), power of 2
//  DF_DEPTH     32   data FIFO depth (128-bit words), power of 2
//  AFULL_MARGIN 4    flag almost-full when free entries <= AFULL_MARGIN
//  CAL_CYCLES   64   clocks after reset release before ddr_phy_rdy_o rises
//  RD_LATENCY   8    clocks from command pop to first read beat (>=2)
// PORTS
//  clk             in   1    sole clock
//  reset           in   1    asynchronous, active-low reset
//  ddr_rd_we_n_i   in   1    1=read, 0=write; latched with ddr_af_we_i
//  ddr_addr_i      in   31   address (64-bit word units); latched with ddr_af_we_i
//  ddr_data_i      in   128  write data; latched with ddr_df_we_i
//  ddr_mask_i      in   16   byte mask, 1=byte NOT written; latched with ddr_df_we_i
//  ddr_af_we_i     in   1    address FIFO push
//  ddr_df_we_i     in   1    data FIFO push
//  ddr_af_afull_o  out  1    address FIFO almost full
//  ddr_df_afull_o  out  1    data FIFO almost full
//  ddr_data_o      out  128  read data, valid with ddr_dvalid_o
//  ddr_dvalid_o    out  1    read beat valid (two consecutive cycles per read)
//  ddr_phy_rdy_o   out  1    calibration complete
//  err_o           out  3    sticky: [0] AF overflow, [1] DF overflow, [2] push before phy_rdy
// BEHAVIOUR
//  - Reset (reset=0): all outputs 0, FIFOs empty, cal counter 0, FSM IDLE, delay line cleared; RAM contents kept.
//  - Reset mid-operation: in-flight reads are discarded; no dvalid is emitted after reset release for pre-reset commands.
//  - Calibration: counter runs from reset release; ddr_phy_rdy_o=1 on cycle CAL_CYCLES and stays 1.
//  - Pushes while phy_rdy=0 are dropped and set err_o[2].
//  - Push while FIFO full: dropped, sets err_o[0]/[1]. Sticky bits clear only on reset.
//  - afull = (DEPTH - count) <= AFULL_MARGIN, registered (1-cycle lag), so the initiator gets >=AFULL_MARGIN-1 cycles of slack.
//  - Same-cycle push and pop on one FIFO: count unchanged. Pointers wrap modulo depth.
//  - RAM index of beat b (b=0,1): {ddr_addr_i[MEM_AW:2], b}; higher address bits are ignored (aliasing wraps).
//  FSM (one command per 2 cycles max):
//   IDLE: AF empty -> IDLE; head is read -> RD0; head is write and DF count>=2 -> WR0; write with DF count<2 -> stay (waits for data).
//   WR0: pop DF, write beat 0 with mask -> WR1.  WR1: pop DF, write beat 1, pop AF -> IDLE.
//   RD0: inject beat 0 into delay line -> RD1.  RD1: inject beat 1, pop AF -> IDLE.
//  - Read delay line: RD_LATENCY-stage shift of {valid, RAM index}; RAM is read at the final stage, so the first
//    dvalid occurs exactly RD_LATENCY cycles after entering RD0, and the second beat follows in the next cycle.
//  - Read-after-write to the same address returns the new data: writes complete before the subsequent read command is popped.
//  - ddr_data_o holds its last value when ddr_dvalid_o=0.
// CONFIGURATION
//  DDR2_RESP_RANDOM_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1, x^16+x^14+x^13+x^11+1) advances every cycle;
//   when lfsr[1:0]==2'b00 both afull outputs are forced to 1 and the FSM stays in IDLE that cycle (exercises back-pressure).
//   The stall is applied only in IDLE; WR0/WR1/RD0/RD1 always complete.
//  Not defined: no LFSR; afull is driven purely from FIFO occupancy; the FSM never stalls artificially.
// TESTING
//  1. Release reset, no traffic -> ddr_phy_rdy_o rises on cycle 64; all other outputs 0; err_o=0.
//  2. Write addr 0x10, data A then B with mask 0, then read 0x10 -> dvalid exactly 8 cycles after RD0, beats A then B.
//  3. Write 0x20 with mask 16'h00FF over existing data 128'h0 -> read returns upper 8 bytes new, lower 8 bytes 0.
//  4. Push 16 reads back to back without pops possible (pre-ready) -> err_o[2]=1; after ready, 13 pushes -> af_afull=1, 17th push into a full FIFO sets err_o[0].
//  5. Write command with its data arriving 10 cycles later -> FSM waits in IDLE; no RAM write and no AF pop until DF count>=2.
//  6. Assert reset while 3 reads are in the delay line -> no dvalid after release; phy_rdy recalibrates over 64 cycles.

Source files
------------

// File: rtl/ddr2_ui_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ddr2_ui_responder
//  Description : Cycle-level responder for the DDR2 controller user interface.
//                Takes address/data FIFO pushes, stores masked write bursts in
//                an internal RAM and returns read bursts as two 128-bit beats
//                a fixed number of cycles after the command is started.
//                Reports almost-full back-pressure and phy-ready after a
//                calibration delay. Optional random IDLE stalls are enabled
//                by defining DDR2_RESP_RANDOM_STALL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr2_ui_responder #(
    parameter int MEM_AW       = 8,
    parameter int AF_DEPTH     = 16,
    parameter int DF_DEPTH     = 32,
    parameter int AFULL_MARGIN = 4,
    parameter int CAL_CYCLES   = 64,
    parameter int RD_LATENCY   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ddr_rd_we_n_i,
    input  logic [30:0]  ddr_addr_i,
    input  logic [127:0] ddr_data_i,
    input  logic [15:0]  ddr_mask_i,
    input  logic         ddr_af_we_i,
    input  logic         ddr_df_we_i,
    output logic         ddr_af_afull_o,
    output logic         ddr_df_afull_o,
    output logic [127:0] ddr_data_o,
    output logic         ddr_dvalid_o,
    output logic         ddr_phy_rdy_o,
    output logic [2:0]   err_o
);

    localparam int c_AAW = $clog2(AF_DEPTH);
    localparam int c_DAW = $clog2(DF_DEPTH);
    localparam int c_CW  = $clog2(CAL_CYCLES + 1);
    localparam int c_DL  = RD_LATENCY - 1;   // output register is the last stage
    localparam int c_AEW = MEM_AW;           // {read flag, burst base index}
    localparam int c_DEW = 144;              // {mask, data}

    localparam logic [c_AAW:0] c_AF_FULL = (c_AAW + 1)'(AF_DEPTH);
    localparam logic [c_DAW:0] c_DF_FULL = (c_DAW + 1)'(DF_DEPTH);
    localparam logic [c_AAW:0] c_AF_THR  = (c_AAW + 1)'(AF_DEPTH - AFULL_MARGIN);
    localparam logic [c_DAW:0] c_DF_THR  = (c_DAW + 1)'(DF_DEPTH - AFULL_MARGIN);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_WR0  = 3'd1;
    localparam logic [2:0] c_WR1  = 3'd2;
    localparam logic [2:0] c_RD0  = 3'd3;
    localparam logic [2:0] c_RD1  = 3'd4;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [c_CW-1:0]   r_cal_cnt;
    logic              r_phy_rdy;

    logic [c_AEW-1:0]  r_af_mem [AF_DEPTH];
    logic [c_AAW-1:0]  r_af_wr;
    logic [c_AAW-1:0]  r_af_rd;
    logic [c_AAW:0]    r_af_cnt;
    logic              r_af_afull;

    logic [c_DEW-1:0]  r_df_mem [DF_DEPTH];
    logic [c_DAW-1:0]  r_df_wr;
    logic [c_DAW-1:0]  r_df_rd;
    logic [c_DAW:0]    r_df_cnt;
    logic              r_df_afull;

    logic [127:0]      r_ram [2**MEM_AW];

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic              r_dl_vld [c_DL];
    logic [MEM_AW-1:0] r_dl_idx [c_DL];

    logic [127:0]      r_data;
    logic              r_dvalid;
    logic [2:0]        r_err;

    logic              w_af_full;
    logic              w_df_full;
    logic              w_af_empty;
    logic              w_af_push;
    logic              w_df_push;
    logic              w_af_pop;
    logic              w_df_pop;
    logic [c_AEW-1:0]  w_af_head;
    logic              w_head_rd;
    logic [MEM_AW-2:0] w_head_base;
    logic [c_DEW-1:0]  w_df_head;
    logic              w_df_has2;
    logic              w_beat;
    logic [MEM_AW-1:0] w_ram_idx;
    logic              w_ram_we;
    logic              w_inject;
    logic              w_stall;
    logic              w_unused;

    // Address bits outside the burst base are intentionally ignored (aliasing)
    assign w_unused = ^{ddr_addr_i[30:MEM_AW+1], ddr_addr_i[1:0]};

    // ------------------------------------------------------------------------
    // Optional random IDLE stall source
    // ------------------------------------------------------------------------
`ifdef DDR2_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Calibration
    // ------------------------------------------------------------------------
    // Count clocks from reset release; phy_rdy rises on clock CAL_CYCLES and sticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cal_cnt <= '0;
            r_phy_rdy <= 1'b0;
        end else if (!r_phy_rdy) begin
            r_cal_cnt <= r_cal_cnt + c_CW'(1);
            if (r_cal_cnt == c_CW'(CAL_CYCLES - 1)) begin
                r_phy_rdy <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    assign w_af_full  = (r_af_cnt == c_AF_FULL);
    assign w_df_full  = (r_df_cnt == c_DF_FULL);
    assign w_af_empty = (r_af_cnt == '0);
    assign w_af_push  = ddr_af_we_i && r_phy_rdy && !w_af_full;
    assign w_df_push  = ddr_df_we_i && r_phy_rdy && !w_df_full;
    assign w_af_pop   = (r_state == c_WR1) || (r_state == c_RD1);
    assign w_df_pop   = (r_state == c_WR0) || (r_state == c_WR1);

    assign w_af_head   = r_af_mem[r_af_rd];
    assign w_head_rd   = w_af_head[c_AEW-1];
    assign w_head_base = w_af_head[MEM_AW-2:0];
    assign w_df_head   = r_df_mem[r_df_rd];
    assign w_df_has2   = (r_df_cnt >= (c_DAW + 1)'(2));

    // FIFO storage; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (w_af_push) begin
            r_af_mem[r_af_wr] <= {ddr_rd_we_n_i, ddr_addr_i[MEM_AW:2]};
        end
        if (w_df_push) begin
            r_df_mem[r_df_wr] <= {ddr_mask_i, ddr_data_i};
        end
    end

    // Address FIFO pointers, occupancy and registered almost-full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_af_wr    <= '0;
            r_af_rd    <= '0;
            r_af_cnt   <= '0;
            r_af_afull <= 1'b0;
        end else begin
            if (w_af_push) r_af_wr <= r_af_wr + c_AAW'(1);
            if (w_af_pop)  r_af_rd <= r_af_rd + c_AAW'(1);
            if (w_af_push && !w_af_pop) begin
                r_af_cnt <= r_af_cnt + (c_AAW + 1)'(1);
            end else if (!w_af_push && w_af_pop) begin
                r_af_cnt <= r_af_cnt - (c_AAW + 1)'(1);
            end
            r_af_afull <= (r_af_cnt >= c_AF_THR);
        end
    end

    // Data FIFO pointers, occupancy and registered almost-full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_df_wr    <= '0;
            r_df_rd    <= '0;
            r_df_cnt   <= '0;
            r_df_afull <= 1'b0;
        end else begin
            if (w_df_push) r_df_wr <= r_df_wr + c_DAW'(1);
            if (w_df_pop)  r_df_rd <= r_df_rd + c_DAW'(1);
            if (w_df_push && !w_df_pop) begin
                r_df_cnt <= r_df_cnt + (c_DAW + 1)'(1);
            end else if (!w_df_push && w_df_pop) begin
                r_df_cnt <= r_df_cnt - (c_DAW + 1)'(1);
            end
            r_df_afull <= (r_df_cnt >= c_DF_THR);
        end
    end

    // Sticky error flags: overflow drops and pushes before calibration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 3'b000;
        end else begin
            if (ddr_af_we_i && r_phy_rdy && w_af_full)    r_err[0] <= 1'b1;
            if (ddr_df_we_i && r_phy_rdy && w_df_full)    r_err[1] <= 1'b1;
            if ((ddr_af_we_i || ddr_df_we_i) && !r_phy_rdy) r_err[2] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------------
    // Next-state: a write waits in IDLE until both data beats are queued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!w_af_empty && !w_stall) begin
                    if (w_head_rd) begin
                        w_state_nxt = c_RD0;
                    end else if (w_df_has2) begin
                        w_state_nxt = c_WR0;
                    end
                end
            end
            c_WR0:   w_state_nxt = c_WR1;
            c_WR1:   w_state_nxt = c_IDLE;
            c_RD0:   w_state_nxt = c_RD1;
            c_RD1:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_beat    = (r_state == c_WR1) || (r_state == c_RD1);
    assign w_ram_idx = {w_head_base, w_beat};
    assign w_ram_we  = (r_state == c_WR0) || (r_state == c_WR1);
    assign w_inject  = (r_state == c_RD0) || (r_state == c_RD1);

    // Byte-masked RAM write; a set mask bit leaves that byte untouched
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 16; b++) begin
                if (!w_df_head[128 + b]) begin
                    r_ram[w_ram_idx][8*b +: 8] <= w_df_head[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read delay line and output beat register
    // ------------------------------------------------------------------------
    // Shift {valid, index} towards the output; cleared by reset to drop reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DL; i++) begin
                r_dl_vld[i] <= 1'b0;
                r_dl_idx[i] <= '0;
            end
        end else begin
            r_dl_vld[0] <= w_inject;
            r_dl_idx[0] <= w_ram_idx;
            for (int i = 1; i < c_DL; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_idx[i] <= r_dl_idx[i-1];
            end
        end
    end

    // RAM is read at the last stage so earlier writes are always visible
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dvalid <= 1'b0;
            r_data   <= '0;
        end else begin
            r_dvalid <= r_dl_vld[c_DL-1];
            if (r_dl_vld[c_DL-1]) begin
                r_data <= r_ram[r_dl_idx[c_DL-1]];
            end
        end
    end

    assign ddr_af_afull_o = r_af_afull | w_stall;
    assign ddr_df_afull_o = r_df_afull | w_stall;
    assign ddr_data_o     = r_data;
    assign ddr_dvalid_o   = r_dvalid;
    assign ddr_phy_rdy_o  = r_phy_rdy;
    assign err_o          = r_err;

endmodule
`default_nettype wire
